seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Parametrised successor to the timer's combinational BCD-to-7-segment decoder.
- Drives NUM_DIGITS BCD digits onto one shared segment bus by time-multiplexing, with one-hot digit select.
- Adds frame-synchronous input capture, leading-zero blanking, per-digit blinking and selectable output polarity.
- Sits between the timer counters (minutes, seconds tens, seconds ones) and the board display pins.

Parameters:
- NUM_DIGITS, 3: number of BCD digits; digit 0 is least significant.
- SCAN_DIV, 4: clock cycles each digit is held, ≥1.
- BLINK_FRAMES, 8: full scan frames per blink half-period, ≥1.
- SEG_ACTIVE_LOW, 0: 1 inverts seg_out at the pins.
- AN_ACTIVE_LOW, 0: 1 inverts an_out at the pins.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  1 = scan runs; 0 = scan frozen and display dark.
- digits_in  in  4*NUM_DIGITS  packed BCD; digit i is at [4i+3:4i].
- blank_lz  in  1  leading-zero blanking enable.
- blink_mask  in  NUM_DIGITS  bit i = 1 makes digit i blink.
- seg_out  out  7  segments {a,b,c,d,e,f,g}, a in bit 6.
- an_out  out  NUM_DIGITS  one-hot digit select.
- frame_start  out  1  one-cycle pulse when shadow data is captured.

Behaviour:
- Reset (async): prescaler=0, idx=0, shadow=0, blink_cnt=0, blink_phase=0. seg_out and an_out go inactive, i.e. all 0 at the logical level before polarity inversion. frame_start=0.
- Prescaler counts 0..SCAN_DIV-1 while enable=1. At SCAN_DIV-1 it wraps to 0 and idx advances, wrapping from NUM_DIGITS-1 to 0.
- End of frame is prescaler==SCAN_DIV-1 and idx==NUM_DIGITS-1 with enable=1. In that cycle:
  - shadow <= digits_in;
  - frame_start registers 1 (visible the next cycle);
  - blink_cnt increments; at BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
- digits_in changes mid-frame are invisible until the next frame.
- Outputs are registered, one cycle after the state they encode. an_out bit idx = 1. seg_out = decode(shadow[idx]) unless the digit is blanked.
- Decode table (a..g):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - codes 10-15 = 0000001 (dash)
- Leading-zero blank: digit i (i>0) is blanked when blank_lz=1 and shadow digits i..NUM_DIGITS-1 are all 0. Digit 0 is never lz-blanked.
- Blink blank: digit i is blanked when blink_phase=1 and blink_mask[i]=1.
- A blanked digit gives seg_out=0000000; an_out still selects it, so the scan timing is unchanged.
- enable=0: prescaler, idx, blink_cnt and shadow hold. The next cycle seg_out and an_out are inactive and frame_start is 0. When enable returns, the scan resumes from the held position.
- Polarity inversion is applied after all of the above.
- Reset mid-frame: immediate dark outputs. After release the scan restarts at digit 0 with shadow=0 and shows "000", or "0" if blank_lz=1. New data appears only after the first end of frame.

Test Plan:
- Defaults; reset, digits_in=0x159, enable=1 -> frame 1 shows 0 on all digits. From frame 2, each for 4 cycles: an_out=001 seg 1111011, an_out=010 seg 1011011, an_out=100 seg 0110000. frame_start pulses every 12 cycles.
- digits_in=0x005, blank_lz=1 -> digit0 seg 1011011; digits 1,2 seg 0000000 with an_out still cycling. digits_in=0x000 -> only digit0 shows 1111110. digits_in=0x105 -> digit1 shows 1111110, not blanked.
- BLINK_FRAMES=2, blink_mask=001, digits_in=0x123 -> digit0 shows 1111001 for 2 frames, then 0000000 for 2 frames, repeating. Digits 1 and 2 are never dark.
- digits_in changed from 0x111 to 0x777 in the middle of digit1's slot -> rest of that frame shows 1; next frame shows 1110000 on all digits.
- digits_in=0x0A9 -> digit1 shows 0000001, digit0 shows 1111011. With SEG_ACTIVE_LOW=1 and AN_ACTIVE_LOW=1, the same values appear bitwise inverted; reset state is all-ones.
- enable low for 10 cycles in the middle of digit1's slot -> outputs dark, idx and prescaler frozen. After re-enable, digit1 completes its remaining cycles. Async reset asserted mid-cycle -> outputs dark within the same cycle.

Source files
------------

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_driver
//  Brief    : Time-multiplexed BCD to 7-segment scan driver with frame-
//             synchronous capture, leading-zero blanking, blink and polarity.
//  Revision : 1.0
// ============================================================================
module seg7_scan_driver #(
    parameter int NUM_DIGITS     = 3,
    parameter int SCAN_DIV       = 4,
    parameter int BLINK_FRAMES   = 8,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit AN_ACTIVE_LOW  = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    blank_lz,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_start
);

    localparam int c_PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int c_BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(SCAN_DIV - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NUM_DIGITS - 1);
    localparam logic [c_BLK_W-1:0] c_BLK_LAST = c_BLK_W'(BLINK_FRAMES - 1);

    logic [c_PRE_W-1:0]      r_prescaler;
    logic [c_IDX_W-1:0]      r_idx;
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [c_BLK_W-1:0]      r_blink_cnt;
    logic                    r_blink_phase;
    logic [6:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    r_frame_start;

    logic                    w_slot_end;
    logic                    w_frame_end;
    logic                    w_run_zero;
    logic [NUM_DIGITS-1:0]   w_lz_blank;
    logic [NUM_DIGITS-1:0]   w_onehot;
    logic [3:0]              w_cur_digit;
    logic                    w_cur_blank;
    logic [6:0]              w_seg_next;

    function automatic logic [6:0] f_decode(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'b1111110;
            4'd1:    seg = 7'b0110000;
            4'd2:    seg = 7'b1101101;
            4'd3:    seg = 7'b1111001;
            4'd4:    seg = 7'b0110011;
            4'd5:    seg = 7'b1011011;
            4'd6:    seg = 7'b1011111;
            4'd7:    seg = 7'b1110000;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1111011;
            default: seg = 7'b0000001;
        endcase
        return seg;
    endfunction

    assign w_slot_end  = (r_prescaler == c_PRE_LAST);
    assign w_frame_end = w_slot_end && (r_idx == c_IDX_LAST);

    // Walk from the most significant digit down: a digit is a leading zero
    // while every digit at or above it is zero. Digit 0 always shows.
    always_comb begin
        w_lz_blank = '0;
        w_run_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_run_zero = w_run_zero && (r_shadow[4*i +: 4] == 4'd0);
            if (i > 0) begin
                w_lz_blank[i] = blank_lz && w_run_zero;
            end
        end
    end

    always_comb begin
        w_onehot    = '0;
        w_cur_digit = 4'd0;
        w_cur_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == c_IDX_W'(i)) begin
                w_onehot[i] = 1'b1;
                w_cur_digit = r_shadow[4*i +: 4];
                w_cur_blank = w_lz_blank[i] || (r_blink_phase && blink_mask[i]);
            end
        end
        w_seg_next = w_cur_blank ? 7'b0000000 : f_decode(w_cur_digit);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prescaler   <= '0;
            r_idx         <= '0;
            r_shadow      <= '0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_seg         <= '0;
            r_an          <= '0;
            r_frame_start <= 1'b0;
        end else if (enable) begin
            r_seg         <= w_seg_next;
            r_an          <= w_onehot;
            r_frame_start <= w_frame_end;

            if (w_slot_end) begin
                r_prescaler <= '0;
                r_idx       <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                r_prescaler <= r_prescaler + 1'b1;
            end

            if (w_frame_end) begin
                r_shadow <= digits_in;
                if (r_blink_cnt == c_BLK_LAST) begin
                    r_blink_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 1'b1;
                end
            end
        end else begin
            // Scan position, shadow and blink state hold; only the pins go dark.
            r_seg         <= '0;
            r_an          <= '0;
            r_frame_start <= 1'b0;
        end
    end

    assign seg_out     = r_seg ^ {7{SEG_ACTIVE_LOW}};
    assign an_out      = r_an ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_scan_driver
//  Brief    : Scoreboard bench for seg7_scan_driver (default and inverted-
//             polarity/fast-blink instances driven from shared stimulus).
//  Revision : 1.0
// ============================================================================
module tb_seg7_scan_driver;

    localparam logic [6:0] c_S0 = 7'b1111110;
    localparam logic [6:0] c_S1 = 7'b0110000;
    localparam logic [6:0] c_S2 = 7'b1101101;
    localparam logic [6:0] c_S3 = 7'b1111001;
    localparam logic [6:0] c_S5 = 7'b1011011;
    localparam logic [6:0] c_S7 = 7'b1110000;
    localparam logic [6:0] c_S9 = 7'b1111011;
    localparam logic [6:0] c_SD = 7'b0000001;
    localparam logic [6:0] c_SB = 7'b0000000;

    typedef struct packed {
        logic [2:0] an;
        logic [6:0] seg;
        logic [7:0] len;
        logic [1:0] fs;
    } slot_t;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [11:0] digits_in;
    logic        blank_lz;
    logic [2:0]  blink_mask;
    logic [6:0]  seg_a, seg_b;
    logic [2:0]  an_a, an_b;
    logic        fs_a, fs_b;
    logic        mon_en;

    int checks;
    int failures;

    slot_t q_a[$];
    slot_t q_b[$];

    seg7_scan_driver u_dut_a (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .digits_in  (digits_in),
        .blank_lz   (blank_lz),
        .blink_mask (blink_mask),
        .seg_out    (seg_a),
        .an_out     (an_a),
        .frame_start(fs_a)
    );

    seg7_scan_driver #(
        .BLINK_FRAMES  (2),
        .SEG_ACTIVE_LOW(1'b1),
        .AN_ACTIVE_LOW (1'b1)
    ) u_dut_b (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .digits_in  (digits_in),
        .blank_lz   (blank_lz),
        .blink_mask (blink_mask),
        .seg_out    (seg_b),
        .an_out     (an_b),
        .frame_start(fs_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // m bit0 -> default instance, bit1 -> inverted/fast-blink instance
    task automatic slot(input int m, input logic [2:0] an, input logic [6:0] seg,
                        input int len, input int fs);
        slot_t e;
        e.an  = an;
        e.seg = seg;
        e.len = 8'(len);
        e.fs  = 2'(fs);
        if (m[0]) q_a.push_back(e);
        if (m[1]) q_b.push_back(e);
    endtask

    task automatic frame(input int m, input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2);
        slot(m, 3'b001, s0, 4, 0);
        slot(m, 3'b010, s1, 4, 0);
        slot(m, 3'b100, s2, 4, 1);
    endtask

    task automatic check_slot(input int d, input logic [2:0] an, input logic [6:0] seg,
                              input int len, input int fs);
        slot_t e;
        bit    have;
        have = 1'b0;
        checks++;
        if (d == 0) begin
            if (q_a.size() > 0) begin e = q_a.pop_front(); have = 1'b1; end
        end else begin
            if (q_b.size() > 0) begin e = q_b.pop_front(); have = 1'b1; end
        end
        if (!have) begin
            failures++;
            $display("FAIL slot dut%0d unexpected: an=%b seg=%b len=%0d fs=%0d, required no slot",
                     d, an, seg, len, fs);
        end else if (e.an != an || e.seg != seg || int'(e.len) != len || int'(e.fs) != fs) begin
            failures++;
            $display("FAIL slot dut%0d: got an=%b seg=%b len=%0d fs=%0d, required an=%b seg=%b len=%0d fs=%0d",
                     d, an, seg, len, fs, e.an, e.seg, int'(e.len), int'(e.fs));
        end
    endtask

    // A slot is a maximal run of identical non-zero {an,seg}; fs code is
    // 0 = no frame_start, 1 = only on the run's last cycle, 2 = elsewhere.
    initial begin : p_monitor
        logic [2:0] prev_an  [2];
        logic [6:0] prev_seg [2];
        int         run_len  [2];
        logic       fs_last  [2];
        logic       fs_early [2];
        logic [2:0] cur_an;
        logic [6:0] cur_seg;
        logic       cur_fs;
        for (int d = 0; d < 2; d++) begin
            prev_an[d] = '0; prev_seg[d] = '0; run_len[d] = 0;
            fs_last[d] = 1'b0; fs_early[d] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (d == 0) begin
                    cur_an = an_a; cur_seg = seg_a; cur_fs = fs_a;
                end else begin
                    cur_an = ~an_b; cur_seg = ~seg_b; cur_fs = fs_b;
                end
                if (reset || !mon_en) begin
                    prev_an[d] = '0; prev_seg[d] = '0; run_len[d] = 0;
                    fs_last[d] = 1'b0; fs_early[d] = 1'b0;
                end else begin
                    if (prev_an[d] != 3'b000 && (cur_an != prev_an[d] || cur_seg != prev_seg[d]))
                        check_slot(d, prev_an[d], prev_seg[d], run_len[d],
                                   fs_early[d] ? 2 : (fs_last[d] ? 1 : 0));
                    if (cur_an == 3'b000) begin
                        checks++;
                        if (cur_seg != 7'b0000000 || cur_fs) begin
                            failures++;
                            $display("FAIL dark dut%0d: seg=%b frame_start=%b, required seg=0000000 frame_start=0",
                                     d, cur_seg, cur_fs);
                        end
                        run_len[d] = 0;
                    end else if (cur_an != prev_an[d] || cur_seg != prev_seg[d]) begin
                        run_len[d]  = 1;
                        fs_early[d] = 1'b0;
                        fs_last[d]  = cur_fs;
                    end else begin
                        run_len[d]++;
                        if (fs_last[d]) fs_early[d] = 1'b1;
                        fs_last[d] = cur_fs;
                    end
                    prev_an[d]  = cur_an;
                    prev_seg[d] = cur_seg;
                end
            end
        end
    end

    // Reset is asserted between clock edges so the dark check also covers
    // the asynchronous path.
    task automatic do_reset(input logic [11:0] d, input logic lz, input logic [2:0] bm);
        @(posedge clk);
        #3;
        mon_en = 1'b0;
        reset  = 1'b1;
        #1;
        checks++;
        if (seg_a !== 7'b0000000 || an_a !== 3'b000 || fs_a !== 1'b0) begin
            failures++;
            $display("FAIL reset dut0: seg=%b an=%b fs=%b, required seg=0000000 an=000 fs=0",
                     seg_a, an_a, fs_a);
        end
        checks++;
        if (seg_b !== 7'b1111111 || an_b !== 3'b111 || fs_b !== 1'b0) begin
            failures++;
            $display("FAIL reset dut1: seg=%b an=%b fs=%b, required seg=1111111 an=111 fs=0",
                     seg_b, an_b, fs_b);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        digits_in  = d;
        blank_lz   = lz;
        blink_mask = bm;
        enable     = 1'b1;
        reset      = 1'b0;
        mon_en     = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        mon_en = 1'b0;
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            failures++;
            $display("FAIL drain: pending dut0=%0d dut1=%0d after %0d cycles, required 0 pending",
                     q_a.size(), q_b.size(), n);
            q_a.delete();
            q_b.delete();
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        mon_en     = 1'b0;
        reset      = 1'b1;
        enable     = 1'b0;
        digits_in  = '0;
        blank_lz   = 1'b0;
        blink_mask = '0;

        // Basic scan: first frame shows the reset shadow, then 1-5-9.
        do_reset(12'h159, 1'b0, 3'b000);
        frame(3, c_S0, c_S0, c_S0);
        frame(3, c_S9, c_S5, c_S1);
        frame(3, c_S9, c_S5, c_S1);
        drain();

        // Leading-zero blanking.
        do_reset(12'h005, 1'b1, 3'b000);
        frame(3, c_S0, c_SB, c_SB);
        frame(3, c_S5, c_SB, c_SB);
        drain();

        do_reset(12'h000, 1'b1, 3'b000);
        frame(3, c_S0, c_SB, c_SB);
        frame(3, c_S0, c_SB, c_SB);
        drain();

        do_reset(12'h105, 1'b1, 3'b000);
        frame(3, c_S0, c_SB, c_SB);
        frame(3, c_S5, c_S0, c_S1);
        drain();

        // Blink on digit 0: instance 1 toggles every 2 frames, instance 0 every 8.
        do_reset(12'h123, 1'b0, 3'b001);
        frame(1, c_S0, c_S0, c_S0);
        for (int f = 0; f < 4; f++) frame(1, c_S3, c_S2, c_S1);
        frame(2, c_S0, c_S0, c_S0);
        frame(2, c_S3, c_S2, c_S1);
        frame(2, c_SB, c_S2, c_S1);
        frame(2, c_SB, c_S2, c_S1);
        frame(2, c_S3, c_S2, c_S1);
        drain();

        // Input change in the middle of frame 2's digit-1 slot.
        do_reset(12'h111, 1'b0, 3'b000);
        frame(3, c_S0, c_S0, c_S0);
        frame(3, c_S1, c_S1, c_S1);
        frame(3, c_S7, c_S7, c_S7);
        repeat (18) @(posedge clk);
        #1;
        digits_in = 12'h777;
        drain();

        // Out-of-range code shows a dash.
        do_reset(12'h0A9, 1'b0, 3'b000);
        frame(3, c_S0, c_S0, c_S0);
        frame(3, c_S9, c_SD, c_S0);
        drain();

        // Enable low for 10 cycles after two cycles of frame 2's digit-1 slot.
        do_reset(12'h159, 1'b0, 3'b000);
        frame(3, c_S0, c_S0, c_S0);
        slot(3, 3'b001, c_S9, 4, 0);
        slot(3, 3'b010, c_S5, 2, 0);
        slot(3, 3'b010, c_S5, 2, 0);
        slot(3, 3'b100, c_S1, 4, 1);
        frame(3, c_S9, c_S5, c_S1);
        repeat (18) @(posedge clk);
        #1;
        enable = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        enable = 1'b1;
        drain();

        // Final asynchronous reset while the scan is running.
        do_reset(12'h000, 1'b0, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
